// File: rtl/avmm_reg_slave_param.sv
// Avalon-MM control/status register file for the packet stream generator:
// fixed wait states, per-register read-only mask, byte enables, SLVERR response.
module avmm_reg_slave_param #(
  parameter int                  DATA_W      = 8,
  parameter int                  ADDR_W      = 8,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_CYCLES = 4,
  parameter int                  ID_IDX      = 5,
  parameter logic [DATA_W-1:0]   ID_VAL      = DATA_W'('h12),
  parameter logic [NUM_REGS-1:0] RO_MASK     = NUM_REGS'('h20)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic [1:0]            response
);

  localparam int         NB          = DATA_W / 8;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT     = 2'd1;
  localparam logic [1:0] ST_ACK      = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] WAIT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                r_is_read;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NB-1:0]       r_be;
  logic                r_waitrequest;
  logic [DATA_W-1:0]   r_readdata;
  logic [1:0]          r_response;

  logic                w_req;
  logic                w_cur_read;
  logic [ADDR_W-1:0]   w_cur_addr;
  logic [NUM_REGS-1:0] w_sel;
  logic                w_in_range;
  logic                w_ro_hit;
  logic                w_err;
  logic                w_enter_ack;
  logic                w_commit;
  logic [DATA_W-1:0]   w_rd_mux;
  logic [DATA_W-1:0]   w_regs [NUM_REGS];

  assign w_req = read | write;

  // With zero wait states the ACK decision is made from the live bus in IDLE,
  // so address decode follows the bus there and the latched copy elsewhere.
  assign w_cur_addr = (r_state == ST_IDLE) ? address : r_addr;
  assign w_cur_read = (r_state == ST_IDLE) ? read    : r_is_read;

  assign w_in_range  = |w_sel;
  assign w_ro_hit    = |(w_sel & RO_MASK);
  assign w_err       = w_cur_read ? !w_in_range : (!w_in_range || w_ro_hit);
  assign w_enter_ack = (w_state_next == ST_ACK);
  assign w_commit    = (r_state == ST_ACK) && !r_is_read;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
          w_cnt_next   = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_next = ST_ACK;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [DATA_W-1:0] RST_VAL = (gi == ID_IDX) ? ID_VAL : '0;
      logic [DATA_W-1:0] r_reg;

      assign w_sel[gi]  = (w_cur_addr == ADDR_W'(gi));
      assign w_regs[gi] = r_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_reg <= RST_VAL;
        end else if (w_commit && w_sel[gi] && !RO_MASK[gi]) begin
          for (int b = 0; b < NB; b++) begin
            if (r_be[b]) r_reg[b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
        end
      end
    end
  endgenerate

  // Out-of-range addresses select nothing, so the mux naturally yields zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sel[i]) w_rd_mux = w_regs[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_is_read     <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_waitrequest <= 1'b1;
      r_readdata    <= '0;
      r_response    <= RESP_OKAY;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == ST_IDLE && w_req) begin
        r_is_read <= read;
        r_addr    <= address;
        r_wdata   <= writedata;
        r_be      <= byteenable;
      end
      r_waitrequest <= !w_enter_ack;
      r_response    <= (w_enter_ack && w_err) ? RESP_SLVERR : RESP_OKAY;
      if (w_enter_ack && w_cur_read) r_readdata <= w_rd_mux;
    end
  end

  assign waitrequest = r_waitrequest;
  assign readdata    = r_readdata;
  assign response    = r_response;

endmodule

// File: tb/tb_avmm_reg_slave_param.sv
// Directed bench: an 8-bit/4-wait and a 32-bit/0-wait instance, both checked every
// cycle against a transaction-level register model plus literal expectations.
module tb_avmm_reg_slave_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  a_address, a_writedata, a_readdata;
  logic        a_read, a_write, a_waitrequest;
  logic [0:0]  a_byteenable;
  logic [1:0]  a_response;

  logic [7:0]  b_address;
  logic [31:0] b_writedata, b_readdata;
  logic        b_read, b_write, b_waitrequest;
  logic [3:0]  b_byteenable;
  logic [1:0]  b_response;

  avmm_reg_slave_param #(.DATA_W(8), .WAIT_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .address(a_address), .read(a_read), .write(a_write),
    .writedata(a_writedata), .byteenable(a_byteenable), .waitrequest(a_waitrequest),
    .readdata(a_readdata), .response(a_response));

  avmm_reg_slave_param #(.DATA_W(32), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .address(b_address), .read(b_read), .write(b_write),
    .writedata(b_writedata), .byteenable(b_byteenable), .waitrequest(b_waitrequest),
    .readdata(b_readdata), .response(b_response));

  logic [31:0] dut_rd   [2];
  logic        dut_wr   [2];
  logic [1:0]  dut_resp [2];
  assign dut_rd[0]   = {24'h0, a_readdata};
  assign dut_rd[1]   = b_readdata;
  assign dut_wr[0]   = a_waitrequest;
  assign dut_wr[1]   = b_waitrequest;
  assign dut_resp[0] = a_response;
  assign dut_resp[1] = b_response;

  // Transaction-level model: register contents, last read data, pending accept.
  logic [31:0] m_regs [2][8];
  logic [31:0] m_rd [2];
  bit          act [2];
  int          ack_cyc [2];
  bit          pend_read [2];
  logic [31:0] pend_rd [2];
  logic [1:0]  pend_resp [2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dmask(input int d);
    return (d == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_regs[d][i] = (i == 5) ? 32'h12 : 32'h0;
      m_rd[d] = 32'h0;
      act[d]  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (act[d] && cyc == ack_cyc[d]) begin
          if (pend_read[d]) m_rd[d] = pend_rd[d];
          check($sformatf("dut%0d waitrequest in accept cycle", d), 32'(dut_wr[d]), 32'd0);
          check($sformatf("dut%0d response in accept cycle", d), 32'(dut_resp[d]), 32'(pend_resp[d]));
        end else begin
          check($sformatf("dut%0d waitrequest outside accept", d), 32'(dut_wr[d]), 32'd1);
          check($sformatf("dut%0d response outside accept", d), 32'(dut_resp[d]), 32'd0);
        end
        check($sformatf("dut%0d readdata", d), dut_rd[d], m_rd[d]);
      end
    end
  end

  task automatic clear_inputs();
    a_address = '0; a_read = 1'b0; a_write = 1'b0; a_writedata = '0; a_byteenable = '0;
    b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0; b_byteenable = '0;
  endtask

  // Asserts reset off the clock edge and checks the outputs react immediately.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    check("reset A waitrequest", 32'(a_waitrequest), 32'd1);
    check("reset A readdata", 32'(a_readdata), 32'd0);
    check("reset A response", 32'(a_response), 32'd0);
    check("reset B waitrequest", 32'(b_waitrequest), 32'd1);
    check("reset B readdata", b_readdata, 32'd0);
    check("reset B response", 32'(b_response), 32'd0);
    model_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("reset applied at t=%0t", $time);
  endtask

  task automatic xfer(input int d, input bit rd, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] got_rd, output logic [1:0] got_resp,
                      output int hi_cnt, output bit acked);
    int w;
    bit commit;
    logic [31:0] nv;
    logic [3:0] lanes;
    w     = (d == 0) ? 4 : 0;
    lanes = (d == 0) ? (be & 4'h1) : be;
    @(negedge clk);
    if (d == 0) begin
      a_address = addr; a_read = rd; a_write = wr; a_writedata = wd[7:0]; a_byteenable = be[0:0];
    end else begin
      b_address = addr; b_read = rd; b_write = wr; b_writedata = wd; b_byteenable = be;
    end
    commit = 1'b0;
    nv = 32'h0;
    pend_read[d] = rd;
    pend_rd[d] = 32'h0;
    if (rd) begin
      pend_rd[d]   = (addr < 8'd8) ? m_regs[d][addr[2:0]] : 32'h0;
      pend_resp[d] = (addr < 8'd8) ? 2'b00 : 2'b10;
    end else if (addr >= 8'd8 || addr == 8'd5) begin
      pend_resp[d] = 2'b10;
    end else begin
      pend_resp[d] = 2'b00;
      commit = 1'b1;
      nv = m_regs[d][addr[2:0]];
      for (int b = 0; b < 4; b++) if (lanes[b]) nv[b*8 +: 8] = wd[b*8 +: 8];
      nv = nv & dmask(d);
    end
    ack_cyc[d] = cyc + 1 + w;
    act[d] = 1'b1;
    hi_cnt = 0; acked = 1'b0; got_rd = 32'h0; got_resp = 2'b00;
    for (int k = 0; k <= w + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= w) begin
        if (dut_wr[d]) hi_cnt++;
      end else begin
        acked = !dut_wr[d]; got_rd = dut_rd[d]; got_resp = dut_resp[d];
      end
    end
    @(negedge clk);
    if (d == 0) begin a_read = 1'b0; a_write = 1'b0; end
    else begin b_read = 1'b0; b_write = 1'b0; end
    act[d] = 1'b0;
    if (commit) m_regs[d][addr[2:0]] = nv;
    $display("dut%0d %s addr=%0d wdata=0x%0h be=%b -> readdata=0x%0h response=%b wait_high=%0d",
             d, rd ? (wr ? "rd+wr" : "read ") : "write", addr, wd, be, got_rd, got_resp, hi_cnt);
  endtask

  // Request on the 4-wait instance that the master abandons while in WAIT.
  task automatic drop_req(input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    @(negedge clk);
    a_read = !wr; a_write = wr; a_address = addr; a_writedata = wd; a_byteenable = 1'b1;
    repeat (2) @(negedge clk);
    a_read = 1'b0; a_write = 1'b0;
    repeat (6) @(negedge clk);
    $display("dut0 dropped %s addr=%0d wdata=0x%0h", wr ? "write" : "read ", addr, wd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          hc;
    bit          ak;
    clear_inputs();
    model_reset();
    apply_reset();

    xfer(0, 1, 0, 8'd5, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A read ID data", rd, 32'h12);
    check("A read ID response", 32'(rs), 32'd0);
    check("A wait-high cycles", 32'(hc), 32'd5);
    check("A accepted", 32'(ak), 32'd1);

    xfer(0, 0, 1, 8'd2, 32'hA5, 4'h1, rd, rs, hc, ak);
    check("A write reg2 response", 32'(rs), 32'd0);
    xfer(0, 1, 0, 8'd2, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A readback reg2", rd, 32'hA5);

    xfer(0, 0, 1, 8'd5, 32'h99, 4'h1, rd, rs, hc, ak);
    check("A write RO response", 32'(rs), 32'd2);
    xfer(0, 1, 0, 8'd5, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A RO reg unchanged", rd, 32'h12);

    xfer(0, 1, 1, 8'd3, 32'h77, 4'h1, rd, rs, hc, ak);
    check("A rd+wr data", rd, 32'h0);
    check("A rd+wr response", 32'(rs), 32'd0);
    xfer(0, 1, 0, 8'd3, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A rd+wr no commit", rd, 32'h0);

    xfer(0, 1, 0, 8'd9, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A read oob data", rd, 32'h0);
    check("A read oob response", 32'(rs), 32'd2);
    xfer(0, 0, 1, 8'd200, 32'h3C, 4'h1, rd, rs, hc, ak);
    check("A write oob response", 32'(rs), 32'd2);

    xfer(0, 0, 1, 8'd4, 32'hFF, 4'h0, rd, rs, hc, ak);
    check("A be=0 write response", 32'(rs), 32'd0);
    xfer(0, 1, 0, 8'd4, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A be=0 no change", rd, 32'h0);

    drop_req(1'b1, 8'd1, 8'h11);
    xfer(0, 1, 0, 8'd1, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A dropped write not committed", rd, 32'h0);
    drop_req(1'b0, 8'd2, 8'h00);
    xfer(0, 1, 0, 8'd2, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A read after dropped read", rd, 32'hA5);

    for (int i = 0; i < 8; i++) xfer(0, 1, 0, 8'(i), 32'h0, 4'h1, rd, rs, hc, ak);

    xfer(1, 1, 0, 8'd5, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B read ID data", rd, 32'h12);
    check("B wait-high cycles", 32'(hc), 32'd1);
    check("B accepted next cycle", 32'(ak), 32'd1);
    xfer(1, 0, 1, 8'd1, 32'hDEAD_BEEF, 4'b0101, rd, rs, hc, ak);
    check("B partial write response", 32'(rs), 32'd0);
    xfer(1, 1, 0, 8'd1, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B partial write lanes 0,2", rd, 32'h00AD_00EF);
    xfer(1, 0, 1, 8'd1, 32'h1122_3344, 4'b1010, rd, rs, hc, ak);
    xfer(1, 1, 0, 8'd1, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B partial write lanes 1,3", rd, 32'h11AD_33EF);
    xfer(1, 0, 1, 8'd5, 32'hCAFE_F00D, 4'hF, rd, rs, hc, ak);
    check("B write RO response", 32'(rs), 32'd2);
    xfer(1, 1, 0, 8'd8, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B read addr NUM_REGS response", 32'(rs), 32'd2);
    xfer(1, 0, 1, 8'd7, 32'h0BAD_CAFE, 4'hF, rd, rs, hc, ak);
    xfer(1, 1, 0, 8'd7, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B read last reg", rd, 32'h0BAD_CAFE);

    @(negedge clk);
    a_write = 1'b1; a_address = 8'd0; a_writedata = 8'h55; a_byteenable = 1'b1;
    repeat (2) @(negedge clk);
    apply_reset();
    xfer(0, 1, 0, 8'd0, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A aborted write not committed", rd, 32'h0);
    xfer(0, 1, 0, 8'd2, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A reg2 cleared by reset", rd, 32'h0);
    xfer(0, 0, 1, 8'd0, 32'h66, 4'h1, rd, rs, hc, ak);
    xfer(0, 1, 0, 8'd0, 32'h0, 4'h1, rd, rs, hc, ak);
    check("A write after reset", rd, 32'h66);
    check("A wait-high after reset", 32'(hc), 32'd5);

    @(negedge clk);
    b_read = 1'b1; b_address = 8'd5; b_byteenable = 4'hF;
    @(posedge clk);
    #1;
    check("B accept before reset", 32'(b_waitrequest), 32'd0);
    check("B readdata before reset", b_readdata, 32'h12);
    apply_reset();
    xfer(1, 1, 0, 8'd5, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B read after reset", rd, 32'h12);
    xfer(1, 1, 0, 8'd7, 32'h0, 4'hF, rd, rs, hc, ak);
    check("B reg7 cleared by reset", rd, 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
